// File: rtl/onehot_strobe_if.sv
// Code/strobe bundle between an encoder or arbiter stage and the one-hot strobe decoder.
// The master side presents codes; the slave side decodes them and drives the strobes.
interface onehot_strobe_if #(
    parameter int N  = 4,
    parameter int CW = 2
);
    logic [CW-1:0] code_in;
    logic          code_valid;
    logic          code_ready;
    logic [N-1:0]  y;
    logic          y_valid;
    logic          busy;
    logic          err;

    modport master (
        output code_in, code_valid,
        input  code_ready, y, y_valid, busy, err
    );

    modport slave (
        input  code_in, code_valid,
        output code_ready, y, y_valid, busy, err
    );
endinterface

// File: rtl/onehot_strobe_decoder.sv
// Sequential binary-to-one-hot decoder: accepts a code, holds its one-hot strobe for HOLD
// cycles, then idles GAP cycles before accepting the next code. All outputs are registered.
module onehot_strobe_decoder #(
    parameter int N    = 4,
    parameter int CW   = 2,
    parameter int HOLD = 2,
    parameter int GAP  = 1
) (
    input  logic           clk,
    input  logic           rst,
    onehot_strobe_if.slave bus
);

    localparam int CNT_MAX_HG = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_MAX    = (CNT_MAX_HG > 2) ? CNT_MAX_HG : 2;
    localparam int CNT_W      = $clog2(CNT_MAX);
    // Only codes that can exceed N need a range check; a full code space never errors.
    localparam bit RANGE_CHECK = (N < (1 << CW));
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [N-1:0] decode(input logic [CW-1:0] code);
        return N'(1) << code;
    endfunction

    function automatic logic is_illegal(input logic [CW-1:0] code);
        if (RANGE_CHECK)
            return ({1'b0, code} >= (CW+1)'(N));
        else
            return 1'b0;
    endfunction

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [N-1:0]     y_p0, y_nx;
    logic             vld_p0, vld_nx;
    logic             busy_p0, busy_nx;
    logic             err_p0, err_nx;
    logic             ready_p0, ready_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        y_nx     = y_p0;
        err_nx   = 1'b0;

        case (state)
            ST_IDLE: begin
                // ready_p0 gates the transfer so the first cycle after reset ignores the bus.
                if (bus.code_valid && ready_p0) begin
                    if (is_illegal(bus.code_in)) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = ST_DRIVE;
                        cnt_nx   = HOLD_LOAD;
                        y_nx     = decode(bus.code_in);
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else if (GAP > 0) begin
                    state_nx = ST_GAP;
                    cnt_nx   = GAP_LOAD;
                    y_nx     = '0;
                end else begin
                    state_nx = ST_IDLE;
                    y_nx     = '0;
                end
            end
            ST_GAP: begin
                if (cnt != '0)
                    cnt_nx = cnt - CNT_W'(1);
                else
                    state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                y_nx     = '0;
            end
        endcase

        ready_nx = (state_nx == ST_IDLE);
        busy_nx  = (state_nx != ST_IDLE);
        vld_nx   = (state_nx == ST_DRIVE);
    end

    // Stage p0: registered state and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            y_p0     <= '0;
            vld_p0   <= 1'b0;
            busy_p0  <= 1'b0;
            err_p0   <= 1'b0;
            ready_p0 <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            y_p0     <= y_nx;
            vld_p0   <= vld_nx;
            busy_p0  <= busy_nx;
            err_p0   <= err_nx;
            ready_p0 <= ready_nx;
        end
    end

    assign bus.y          = y_p0;
    assign bus.y_valid    = vld_p0;
    assign bus.busy       = busy_p0;
    assign bus.err        = err_p0;
    assign bus.code_ready = ready_p0;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Bench for onehot_strobe_decoder: three parameterisations share clk/rst, expected
// per-cycle outputs are queued as stimulus is driven and compared on the falling edge.
module tb_onehot_strobe_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    onehot_strobe_if #(.N(4), .CW(2)) bus0 ();
    onehot_strobe_if #(.N(3), .CW(2)) bus1 ();
    onehot_strobe_if #(.N(4), .CW(2)) bus2 ();

    onehot_strobe_decoder #(.N(4), .CW(2), .HOLD(2), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    onehot_strobe_decoder #(.N(3), .CW(2), .HOLD(2), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    onehot_strobe_decoder #(.N(4), .CW(2), .HOLD(1), .GAP(0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct packed {
        logic [3:0] y;
        logic       yv;
        logic       busy;
        logic       ready;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;

    logic [3:0] obs_y;
    logic       obs_yv, obs_busy, obs_ready, obs_err;
    exp_t       obs;

    always_comb begin
        obs_y = 4'b0; obs_yv = 1'b0; obs_busy = 1'b0; obs_ready = 1'b0; obs_err = 1'b0;
        case (sel)
            0: begin obs_y = bus0.y; obs_yv = bus0.y_valid; obs_busy = bus0.busy;
                     obs_ready = bus0.code_ready; obs_err = bus0.err; end
            1: begin obs_y = {1'b0, bus1.y}; obs_yv = bus1.y_valid; obs_busy = bus1.busy;
                     obs_ready = bus1.code_ready; obs_err = bus1.err; end
            default: begin obs_y = bus2.y; obs_yv = bus2.y_valid; obs_busy = bus2.busy;
                     obs_ready = bus2.code_ready; obs_err = bus2.err; end
        endcase
        obs = {obs_y, obs_yv, obs_busy, obs_ready, obs_err};
    end

    function automatic void push_cycle(logic [3:0] y, logic busy, logic ready, logic err);
        exp_t e;
        e.y = y; e.yv = (y != 4'b0); e.busy = busy; e.ready = ready; e.err = err;
        sb.push_back(e);
    endfunction

    // Expected outputs after accepting code: HOLD strobe cycles, GAP idle-busy cycles, then ready.
    function automatic void push_strobe(int code, int hold, int gap);
        logic [3:0] oh;
        oh = 4'b0001 << code;
        for (int i = 0; i < hold; i++) push_cycle(oh, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < gap; i++)  push_cycle(4'b0, 1'b1, 1'b0, 1'b0);
        push_cycle(4'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic test_reset();
        exp_t e;
        sel = 0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("FAIL reset_async: got y=%b yv=%b busy=%b rdy=%b err=%b, want all 0",
                     obs_y, obs_yv, obs_busy, obs_ready, obs_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 0 before first edge", obs_ready);
        end
        push_cycle(4'b0, 1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_ready_rise: got %b want %b (y,yv,busy,rdy,err)", obs, e);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        sel = 0;
        bus0.code_in = 2'd2; bus0.code_valid = 1'b1;
        push_strobe(2, 2, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL single cyc%0d: got %b want %b (y,yv,busy,rdy,err)", i, obs, e);
            end
            if (i == 0) bus0.code_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sel = 0;
        bus0.code_in = 2'd0; bus0.code_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            push_strobe(c, 2, 1);
            for (int i = 0; sb.size() > 0; i++) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL b2b code%0d cyc%0d: got %b want %b (y,yv,busy,rdy,err)",
                             c, i, obs, e);
                end
            end
            if (c < 3) bus0.code_in = 2'(c + 1);
            else       bus0.code_valid = 1'b0;
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        sel = 1;
        bus1.code_in = 2'd3; bus1.code_valid = 1'b1;
        push_cycle(4'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL illegal_err: got %b want %b (y,yv,busy,rdy,err)", obs, e);
        end
        bus1.code_in = 2'd1;
        push_strobe(1, 2, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL after_err cyc%0d: got %b want %b (y,yv,busy,rdy,err)", i, obs, e);
            end
            if (i == 0) bus1.code_valid = 1'b0;
        end
    endtask

    task automatic test_hold1_gap0();
        exp_t e;
        sel = 2;
        bus2.code_in = 2'd1; bus2.code_valid = 1'b1;
        push_cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        push_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        push_cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        push_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL hold1_gap0 cyc%0d: got %b want %b (y,yv,busy,rdy,err)", i, obs, e);
            end
            if (i == 0) bus2.code_in = 2'd0;
            if (i == 2) bus2.code_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_drive();
        exp_t e;
        sel = 0;
        bus0.code_in = 2'd3; bus0.code_valid = 1'b1;
        @(negedge clk);
        bus0.code_valid = 1'b0;
        checks++;
        if (obs_y !== 4'b1000) begin
            errors++;
            $display("FAIL mid_drive_y: got %b want 1000", obs_y);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("FAIL mid_drive_reset: got %b want 00000000 (y,yv,busy,rdy,err)", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        push_cycle(4'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want %b (y,yv,busy,rdy,err)", obs, e);
        end
        bus0.code_in = 2'd1; bus0.code_valid = 1'b1;
        push_strobe(1, 2, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL post_reset_strobe cyc%0d: got %b want %b (y,yv,busy,rdy,err)",
                         i, obs, e);
            end
            if (i == 0) bus0.code_valid = 1'b0;
        end
    endtask

    initial begin
        bus0.code_in = '0; bus0.code_valid = 1'b0;
        bus1.code_in = '0; bus1.code_valid = 1'b0;
        bus2.code_in = '0; bus2.code_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_hold1_gap0();
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
